id_token_ctrl: RTL
==================

# id_token_ctrl

Identifier-token controller for the character-recognition datapath. Accepts a byte stream over a valid/ready handshake, classifies each character and tracks identifier state: a letter followed by any mix of letters and digits. For every complete identifier it emits one length token over a second valid/ready handshake and keeps a running identifier count. It sits between a character source (UART/ROM reader) and downstream consumers, sequencing recognition so that tokens are never lost under backpressure.

## Interface
- `MAX_LEN`, 31: largest reportable identifier length; longer identifiers saturate.
- `LEN_W`, 6: width of `tok_len`; must satisfy 2^LEN_W > MAX_LEN.
- `CNT_W`, 16: width of `id_count`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `in_char` and `in_last` are valid.
- `in_ready` out 1: controller can accept a character this cycle.
- `in_char` in 8: ASCII character.
- `in_last` in 1: this character ends the stream/line.
- `tok_valid` out 1: token pending.
- `tok_ready` in 1: consumer accepts the token.
- `tok_len` out LEN_W: identifier length, saturated at `MAX_LEN`.
- `tok_trunc` out 1: identifier was longer than `MAX_LEN`.
- `id_active` out 1: the characters accepted since the last separator form a valid identifier prefix.
- `id_count` out CNT_W: number of tokens handshaken since reset; saturates at all-ones.

## Operation
- **Classes:** letter = 'A'–'Z', 'a'–'z'; digit = '0'–'9'; everything else is a separator.
- **Accept:** a character is accepted on a rising edge with `in_valid && in_ready`.
- **States:** IDLE, IN_ID, SKIP, EMIT.
- **IDLE**
  - letter: `len`=1, go to IN_ID.
  - digit: go to SKIP.
  - separator: stay in IDLE.
- **IN_ID**
  - letter or digit: `len` += 1, saturating at `MAX_LEN`.
  - Set sticky `trunc` if a character arrives while `len`==`MAX_LEN`.
  - separator: go to EMIT. The separator is consumed and is not part of the token.
- **SKIP** (digit-led word, not an identifier)
  - letter or digit: stay in SKIP.
  - separator: go to IDLE. No token is produced.
- **`in_last` handling**
  - In IN_ID, or IDLE with a letter: the character is applied first, then go to EMIT.
  - Any other state: go to IDLE. Any SKIP word is dropped.
- **EMIT**
  - `tok_valid`=1; `tok_len`/`tok_trunc` hold registered values; `in_ready`=0.
  - On `tok_ready`: `id_count` += 1 (saturating), clear `len`/`trunc`, go to IDLE.
- **Outputs per state**
  - `in_ready` = 1 in IDLE, IN_ID and SKIP.
  - `id_active` = 1 only in IN_ID.
- **Registers:** `tok_len`, `tok_trunc` and `id_count` are registered outputs.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `tok_valid`=0, `tok_len`=0, `tok_trunc`=0, `id_active`=0, `id_count`=0.
- **Token latency:** `tok_valid` rises the cycle after the terminating character is accepted.
- **Backpressure:**
  - `tok_valid` and its payload stay stable until `tok_ready` is sampled high.
  - `in_ready` is 0 for every EMIT cycle.
  - Minimum EMIT duration is 1 cycle; with `tok_ready` held high, throughput is 1 character/cycle except 1 bubble per token.
- **After a handshake:** `in_ready` is high in the cycle following it. No character is accepted in the handshake cycle itself.
- **`id_active`** follows the state register, 1 cycle after the causing character.
- **Saturation:** `id_count` at all-ones stays at all-ones and the token still completes.
- **`in_valid`=0:** no state change in any state except EMIT, which still completes its handshake.
- **Reset mid-token or mid-EMIT:**
  - The pending token is discarded.
  - All outputs return to their reset values immediately (asynchronous), with no glitch token after release.

## Configuration
- `ID_TOKEN_UNDERSCORE_EN`
  - Defined: '_' is classed as a letter, so it can start or continue an identifier.
  - Undefined: '_' is a separator.
- All other behaviour is identical in both builds.

## Test plan
- **Basic token:** reset, stream "abc " with `tok_ready`=1.
  - `tok_valid` pulses 1 cycle after ' ' with `tok_len`=3, `tok_trunc`=0.
  - `id_count`=1; `id_active` is high for 3 cycles.
- **Digit-led rejection:** stream "5ab a1 ".
  - Exactly one token, with `tok_len`=2.
  - `id_active` stays 0 throughout "5ab".
- **Backpressure:** stream "az," with `tok_ready`=0 for 4 cycles.
  - `tok_valid`=1 and `tok_len`=2 held stable; `in_ready`=0 for 4 cycles.
  - On release, `id_count` increments once.
- **Truncation and `in_last`:** 40 letters with `in_last` on the 40th.
  - `tok_len`=31, `tok_trunc`=1.
  - Next token "x " gives `tok_len`=1, `tok_trunc`=0.
- **Reset mid-token:** assert `rst_n`=0 after "ab".
  - All outputs 0 and `in_ready`=1 immediately.
  - Then "q " yields `tok_len`=1, `id_count`=1.
- **Underscore macro:** stream "_x ".
  - With `ID_TOKEN_UNDERSCORE_EN`: `tok_len`=2.
  - Without it: `tok_len`=1.

Source files
------------

// File: rtl/id_token_ctrl.sv
// ============================================================================
// Module   : id_token_ctrl
// Brief    : Identifier-token controller. Classifies an incoming byte stream,
//            tracks identifiers (letter, then letters/digits) and emits one
//            saturated length token per identifier over a valid/ready port.
// Option   : ID_TOKEN_UNDERSCORE_EN - when defined, '_' counts as a letter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_token_ctrl #(
  parameter int MAX_LEN = 31,
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_trunc,
  output logic             id_active,
  output logic [CNT_W-1:0] id_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IN_ID = 2'd1,
    SKIP  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

  state_t           r_state;
  state_t           w_nxt_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_nxt_len;
  logic             r_trunc;
  logic             w_nxt_trunc;
  logic [CNT_W-1:0] r_count;
  logic             w_count_inc;
  logic             w_accept;
  logic             w_is_letter;
  logic             w_is_digit;
  logic             w_is_word;

  // Character classification; underscore joins the letter class when enabled.
  always_comb begin
    w_is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
`ifdef ID_TOKEN_UNDERSCORE_EN
    w_is_letter = ((in_char >= 8'h41) && (in_char <= 8'h5A)) ||
                  ((in_char >= 8'h61) && (in_char <= 8'h7A)) ||
                  (in_char == 8'h5F);
`else
    w_is_letter = ((in_char >= 8'h41) && (in_char <= 8'h5A)) ||
                  ((in_char >= 8'h61) && (in_char <= 8'h7A));
`endif
    w_is_word   = w_is_letter || w_is_digit;
  end

  assign in_ready  = (r_state != EMIT);
  assign w_accept  = in_valid && in_ready;
  assign tok_valid = (r_state == EMIT);
  assign id_active = (r_state == IN_ID);
  assign tok_len   = r_len;
  assign tok_trunc = r_trunc;
  assign id_count  = r_count;

  // Next-state, length and truncation logic.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_len   = r_len;
    w_nxt_trunc = r_trunc;
    w_count_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_letter) begin
            w_nxt_len   = LEN_W'(1);
            w_nxt_trunc = 1'b0;
            w_nxt_state = in_last ? EMIT : IN_ID;
          end else if (w_is_digit) begin
            w_nxt_state = in_last ? IDLE : SKIP;
          end
        end
      end
      IN_ID: begin
        if (w_accept) begin
          if (w_is_word) begin
            if (r_len == c_max_len) begin
              w_nxt_trunc = 1'b1;
            end else begin
              w_nxt_len = r_len + 1'b1;
            end
            w_nxt_state = in_last ? EMIT : IN_ID;
          end else begin
            // Separator closes the identifier and is not counted.
            w_nxt_state = EMIT;
          end
        end
      end
      SKIP: begin
        if (w_accept && (!w_is_word || in_last)) begin
          w_nxt_state = IDLE;
        end
      end
      EMIT: begin
        if (tok_ready) begin
          w_count_inc = 1'b1;
          w_nxt_len   = '0;
          w_nxt_trunc = 1'b0;
          w_nxt_state = IDLE;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // State, payload and counter registers; reset discards any pending token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_trunc <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_len   <= w_nxt_len;
      r_trunc <= w_nxt_trunc;
      if (w_count_inc && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
